// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned RES_SRC_W  = 2;

    // Operand source selected for the ALU in the execute stage
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Data-cache miss sequencer states
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        REQ    = 2'b01,
        WAIT   = 2'b10,
        RESUME = 2'b11
    } haz_state_t;

    localparam logic [RES_SRC_W-1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_fwd.sv
// Forwarding comparator for one ALU operand; the M-stage match wins over W.
module hazard_fwd
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    output fwd_sel_t              sel
);

    // Pick the youngest in-flight producer of rs; x0 is never forwarded
    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rs == rd_m)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rs == rd_w)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use stall, branch
// flush and a data-cache miss sequencer that freezes the pipeline.
// Optional build macro HAZARD_PERF_EN adds stall/flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MISS_TIMEOUT = 256,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [REG_ADDR_W-1:0] rs1D_i,
    input  logic [REG_ADDR_W-1:0] rs2D_i,
    input  logic [REG_ADDR_W-1:0] rs1E_i,
    input  logic [REG_ADDR_W-1:0] rs2E_i,
    input  logic [REG_ADDR_W-1:0] rdE_i,
    input  logic [REG_ADDR_W-1:0] rdM_i,
    input  logic [REG_ADDR_W-1:0] rdW_i,
    input  logic                  reg_writeM_i,
    input  logic                  reg_writeW_i,
    input  logic [RES_SRC_W-1:0]  result_srcE_i,
    input  logic                  pc_srcE_i,
    input  logic                  cache_missM_i,
    input  logic                  refill_done_i,
    output logic [1:0]            forwardAE_o,
    output logic [1:0]            forwardBE_o,
    output logic                  stallF_o,
    output logic                  stallD_o,
    output logic                  flushD_o,
    output logic                  flushE_o,
    output logic                  mem_stall_o,
    output logic                  refill_req_o,
    output logic                  error_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cycles_o,
    output logic [CNT_WIDTH-1:0]  flush_count_o
`endif
);

    localparam int unsigned TMO_W = $clog2(MISS_TIMEOUT + 1);

    if ((MISS_TIMEOUT < 2) || (CNT_WIDTH < 1)) begin : g_param_check
        $error("hazard_ctrl: MISS_TIMEOUT must be >= 2 and CNT_WIDTH >= 1");
    end

    fwd_sel_t           fwd_a;
    fwd_sel_t           fwd_b;
    logic               lw_stall;
    logic               mem_stall;
    haz_state_t         state_q;
    haz_state_t         state_d;
    logic               refill_req_q;
    logic               error_q;
    logic [TMO_W-1:0]   tmo_cnt_q;

    hazard_fwd u_fwd_a (
        .rs          (rs1E_i),
        .rd_m        (rdM_i),
        .rd_w        (rdW_i),
        .reg_write_m (reg_writeM_i),
        .reg_write_w (reg_writeW_i),
        .sel         (fwd_a)
    );

    hazard_fwd u_fwd_b (
        .rs          (rs2E_i),
        .rd_m        (rdM_i),
        .rd_w        (rdW_i),
        .reg_write_m (reg_writeM_i),
        .reg_write_w (reg_writeW_i),
        .sel         (fwd_b)
    );

    // Load in E whose destination is a source of the instruction in D
    always_comb begin
        lw_stall = (result_srcE_i == RESULT_SRC_LOAD) && (rdE_i != '0) &&
                   ((rs1D_i == rdE_i) || (rs2D_i == rdE_i));
    end

    // Miss sequencer state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Miss sequencer next state; freeze asserts in the cycle the miss is seen
    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        case (state_q)
            RUN: begin
                if (cache_missM_i) begin
                    state_d   = REQ;
                    mem_stall = 1'b1;
                end
            end
            REQ: begin
                state_d   = WAIT;
                mem_stall = 1'b1;
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (refill_done_i) begin
                    state_d = RESUME;
                end
            end
            RESUME: begin
                state_d   = RUN;
                mem_stall = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    // Refill request pulse, timeout counter and sticky timeout flag
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            refill_req_q <= 1'b0;
            error_q      <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            refill_req_q <= (state_d == REQ);
            if ((state_d == WAIT) && (state_q != WAIT)) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == WAIT) && (tmo_cnt_q != TMO_W'(MISS_TIMEOUT))) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
            if ((state_q == WAIT) && !refill_done_i &&
                (tmo_cnt_q == TMO_W'(MISS_TIMEOUT - 1))) begin
                error_q <= 1'b1;
            end
        end
    end

    // Output drive; a frozen pipeline suppresses stalls and flushes, and
    // everything is held low while reset is asserted
    always_comb begin
        forwardAE_o  = rst_ni ? fwd_a : FWD_RF;
        forwardBE_o  = rst_ni ? fwd_b : FWD_RF;
        mem_stall_o  = rst_ni && mem_stall;
        stallF_o     = rst_ni && !mem_stall && lw_stall;
        stallD_o     = rst_ni && !mem_stall && lw_stall;
        flushD_o     = rst_ni && !mem_stall && pc_srcE_i;
        flushE_o     = rst_ni && !mem_stall && (lw_stall || pc_srcE_i);
        refill_req_o = rst_ni && refill_req_q;
        error_o      = rst_ni && error_q;
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_q;

    // Wrapping counters of stalled cycles and front-end flushes
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (mem_stall_o || lw_stall) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
            if (flushD_o) begin
                flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Counter outputs, held low during reset like every other output
    always_comb begin
        stall_cycles_o = rst_ni ? stall_cnt_q : '0;
        flush_count_o  = rst_ni ? flush_cnt_q : '0;
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MISS_TIMEOUT = 4).
module tb_hazard_ctrl;

    localparam int unsigned TMO = 4;
    localparam int unsigned CW  = 16;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [4:0] rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, rdM_i, rdW_i;
    logic       reg_writeM_i, reg_writeW_i;
    logic [1:0] result_srcE_i;
    logic       pc_srcE_i, cache_missM_i, refill_done_i;
    logic [1:0] forwardAE_o, forwardBE_o;
    logic       stallF_o, stallD_o, flushD_o, flushE_o;
    logic       mem_stall_o, refill_req_o, error_o;
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] stall_cycles_o, flush_count_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl #(.MISS_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rs1D_i        (rs1D_i),
        .rs2D_i        (rs2D_i),
        .rs1E_i        (rs1E_i),
        .rs2E_i        (rs2E_i),
        .rdE_i         (rdE_i),
        .rdM_i         (rdM_i),
        .rdW_i         (rdW_i),
        .reg_writeM_i  (reg_writeM_i),
        .reg_writeW_i  (reg_writeW_i),
        .result_srcE_i (result_srcE_i),
        .pc_srcE_i     (pc_srcE_i),
        .cache_missM_i (cache_missM_i),
        .refill_done_i (refill_done_i),
        .forwardAE_o   (forwardAE_o),
        .forwardBE_o   (forwardBE_o),
        .stallF_o      (stallF_o),
        .stallD_o      (stallD_o),
        .flushD_o      (flushD_o),
        .flushE_o      (flushE_o),
        .mem_stall_o   (mem_stall_o),
        .refill_req_o  (refill_req_o),
        .error_o       (error_o)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles_o(stall_cycles_o),
        .flush_count_o (flush_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        rs1D_i = '0; rs2D_i = '0; rs1E_i = '0; rs2E_i = '0;
        rdE_i = '0; rdM_i = '0; rdW_i = '0;
        reg_writeM_i = 1'b0; reg_writeW_i = 1'b0;
        result_srcE_i = 2'b00; pc_srcE_i = 1'b0;
        cache_missM_i = 1'b0; refill_done_i = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        clear_inputs();
        rst_ni = 1'b0;

        // Reset: outputs low even with active stimulus
        rs1E_i = 5'd5; rdM_i = 5'd5; reg_writeM_i = 1'b1;
        cache_missM_i = 1'b1; pc_srcE_i = 1'b1;
        settle();
        check("rst_fwdA", 32'(forwardAE_o), 32'd0);
        check("rst_mem_stall", 32'(mem_stall_o), 32'd0);
        check("rst_flushD", 32'(flushD_o), 32'd0);
        tick(); tick();
        check("rst_refill", 32'(refill_req_o), 32'd0);
        check("rst_error", 32'(error_o), 32'd0);
        check("rst_mem_stall2", 32'(mem_stall_o), 32'd0);
        clear_inputs();
        rst_ni = 1'b1;
        tick();
        check("run_mem_stall", 32'(mem_stall_o), 32'd0);

        // Forwarding priority
        rs1E_i = 5'd5; rdM_i = 5'd5; reg_writeM_i = 1'b1; rdW_i = 5'd5; reg_writeW_i = 1'b1;
        settle();
        check("fwdA_mem", 32'(forwardAE_o), 32'd2);
        rdM_i = 5'd0;
        settle();
        check("fwdA_wb", 32'(forwardAE_o), 32'd1);
        rs1E_i = 5'd0;
        settle();
        check("fwdA_rf", 32'(forwardAE_o), 32'd0);
        rs2E_i = 5'd5; rdM_i = 5'd5; reg_writeM_i = 1'b0;
        settle();
        check("fwdB_wb_nowrM", 32'(forwardBE_o), 32'd1);
        reg_writeM_i = 1'b1; rdW_i = 5'd9;
        settle();
        check("fwdB_mem", 32'(forwardBE_o), 32'd2);
        clear_inputs();

        // Load-use
        result_srcE_i = 2'b01; rdE_i = 5'd7; rs2D_i = 5'd7;
        settle();
        check("lu_stallF", 32'(stallF_o), 32'd1);
        check("lu_stallD", 32'(stallD_o), 32'd1);
        check("lu_flushE", 32'(flushE_o), 32'd1);
        check("lu_flushD", 32'(flushD_o), 32'd0);
        rdE_i = 5'd0; rs2D_i = 5'd0;
        settle();
        check("lu_x0_stallF", 32'(stallF_o), 32'd0);
        check("lu_x0_flushE", 32'(flushE_o), 32'd0);
        result_srcE_i = 2'b00; rdE_i = 5'd7; rs1D_i = 5'd7;
        settle();
        check("lu_noload", 32'(stallF_o), 32'd0);
        result_srcE_i = 2'b01;
        settle();
        check("lu_rs1_stallD", 32'(stallD_o), 32'd1);
        clear_inputs();

        // Branch
        pc_srcE_i = 1'b1;
        settle();
        check("br_flushD", 32'(flushD_o), 32'd1);
        check("br_flushE", 32'(flushE_o), 32'd1);
        check("br_stallF", 32'(stallF_o), 32'd0);
        tick();

        // Miss sequence with a branch pending throughout
        cache_missM_i = 1'b1;
        settle();
        check("ms_t_stall", 32'(mem_stall_o), 32'd1);
        check("ms_t_flushD", 32'(flushD_o), 32'd0);
        check("ms_t_flushE", 32'(flushE_o), 32'd0);
        check("ms_t_req", 32'(refill_req_o), 32'd0);
        tick();
        check("ms_t1_req", 32'(refill_req_o), 32'd1);
        cache_missM_i = 1'b0; refill_done_i = 1'b1;
        settle();
        check("ms_t1_stall", 32'(mem_stall_o), 32'd1);
        check("ms_t1_flushD", 32'(flushD_o), 32'd0);
        tick();
        refill_done_i = 1'b0;
        settle();
        check("ms_t2_req", 32'(refill_req_o), 32'd0);
        check("ms_t2_stall", 32'(mem_stall_o), 32'd1);
        tick();
        refill_done_i = 1'b1;
        settle();
        check("ms_t3_stall", 32'(mem_stall_o), 32'd1);
        tick();
        refill_done_i = 1'b0; cache_missM_i = 1'b1;
        settle();
        check("ms_t4_stall", 32'(mem_stall_o), 32'd1);
        check("ms_t4_flushD", 32'(flushD_o), 32'd0);
        tick();
        cache_missM_i = 1'b0;
        settle();
        check("ms_t5_stall", 32'(mem_stall_o), 32'd0);
        check("ms_t5_flushD", 32'(flushD_o), 32'd1);
        check("ms_t5_flushE", 32'(flushE_o), 32'd1);
        check("ms_t5_req", 32'(refill_req_o), 32'd0);
        pc_srcE_i = 1'b0;

        // refill_done ignored in RUN
        refill_done_i = 1'b1;
        tick();
        refill_done_i = 1'b0;
        settle();
        check("done_in_run", 32'(mem_stall_o), 32'd0);

        // Timeout
        cache_missM_i = 1'b1;
        tick();
        cache_missM_i = 1'b0;
        for (int i = 0; i < int'(TMO); i++) begin
            tick();
            check("tmo_wait_err", 32'(error_o), 32'd0);
        end
        tick();
        check("tmo_err_set", 32'(error_o), 32'd1);
        check("tmo_still_wait", 32'(mem_stall_o), 32'd1);
        tick(); tick();
        check("tmo_err_held", 32'(error_o), 32'd1);
        rst_ni = 1'b0;
        settle();
        check("tmo_rst_err", 32'(error_o), 32'd0);
        check("tmo_rst_stall", 32'(mem_stall_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        settle();
        check("tmo_post_err", 32'(error_o), 32'd0);
        check("tmo_post_stall", 32'(mem_stall_o), 32'd0);
        tick();
        check("tmo_post_stall2", 32'(mem_stall_o), 32'd0);

        // Reset while in WAIT
        cache_missM_i = 1'b1;
        tick();
        cache_missM_i = 1'b0;
        tick();
        check("rw_wait_stall", 32'(mem_stall_o), 32'd1);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        settle();
        check("rw_req0", 32'(refill_req_o), 32'd0);
        check("rw_stall0", 32'(mem_stall_o), 32'd0);
`ifdef HAZARD_PERF_EN
        check("rw_perf_stall0", 32'(stall_cycles_o), 32'd0);
        check("rw_perf_flush0", 32'(flush_count_o), 32'd0);
`endif
        tick();
        check("rw_req1", 32'(refill_req_o), 32'd0);
        check("rw_stall1", 32'(mem_stall_o), 32'd0);
        cache_missM_i = 1'b1;
        settle();
        check("rw_new_stall", 32'(mem_stall_o), 32'd1);
        tick();
        check("rw_new_req", 32'(refill_req_o), 32'd1);
`ifdef HAZARD_PERF_EN
        check("rw_perf_stall1", 32'(stall_cycles_o), 32'd1);
`endif
        cache_missM_i = 1'b0;
        tick();
        check("rw_new_req_off", 32'(refill_req_o), 32'd0);
        refill_done_i = 1'b1;
        tick();
        refill_done_i = 1'b0;
        tick();
        settle();
        check("rw_resume_done", 32'(mem_stall_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller: the driving end of the decode/execute pipe register's flush (`clr_i`) and of the stall enables of the fetch/decode registers.
- Consumes register addresses and control bits coming back from the E, M and W stages; produces forwarding selects, stalls and flushes.
- Owns a data-cache miss sequencer: freezes the whole pipeline, requests a refill, waits for completion, then resumes.

Parameters:
- MISS_TIMEOUT, 256: cycles allowed in MISS_WAIT before the sticky error is raised; must be ≥ 2.
- CNT_WIDTH, 32: width of the optional performance counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- rs1D_i, rs2D_i  in  5  decode-stage source register addresses.
- rs1E_i, rs2E_i  in  5  execute-stage source register addresses.
- rdE_i, rdM_i, rdW_i  in  5  destination register addresses for E, M and W.
- reg_writeM_i, reg_writeW_i  in  1  register write enables for M and W.
- result_srcE_i  in  2  E-stage result select; value 2'b01 means load.
- pc_srcE_i  in  1  taken branch or jump resolved in E.
- cache_missM_i  in  1  data-cache miss for the M-stage access.
- refill_done_i  in  1  memory reports the refill is complete.
- forwardAE_o, forwardBE_o  out  2  ALU operand A/B forwarding select.
- stallF_o, stallD_o  out  1  hold the PC and the fetch/decode register.
- flushD_o, flushE_o  out  1  clear the fetch/decode and decode/execute registers.
- mem_stall_o  out  1  freeze all pipeline registers and the PC.
- refill_req_o  out  1  refill request pulse, registered.
- error_o  out  1  sticky refill-timeout flag.

Behaviour:
- Forwarding (combinational):
  - forwardAE_o = 2'b10 when rs1E_i == rdM_i, reg_writeM_i = 1 and rdM_i ≠ 0.
  - Otherwise 2'b01 when rs1E_i == rdW_i, reg_writeW_i = 1 and rdW_i ≠ 0.
  - Otherwise 2'b00.
  - The M match has priority over the W match. forwardBE_o follows the same rules using rs2E_i.
- Load-use hazard:
  - lw_stall = (result_srcE_i == 2'b01) and rdE_i ≠ 0 and (rs1D_i == rdE_i or rs2D_i == rdE_i).
  - stallF_o = stallD_o = lw_stall.
- Control hazard:
  - flushD_o = pc_srcE_i.
  - flushE_o = lw_stall or pc_srcE_i.
- Miss FSM states: RUN, REQ, WAIT, RESUME.
  - RUN: on cache_missM_i = 1, go to REQ.
  - REQ: lasts exactly 1 cycle; refill_req_o = 1 in this cycle only; then go to WAIT.
  - WAIT: on refill_done_i = 1, go to RESUME. refill_done_i is ignored in every other state.
  - RESUME: 1 cycle for the cache array read-out; then go to RUN. cache_missM_i is ignored in RESUME.
- mem_stall_o:
  - mem_stall_o = (state == RUN and cache_missM_i) or state ∈ {REQ, WAIT, RESUME}.
  - It asserts combinationally in the same cycle the miss is detected.
- Priority while mem_stall_o = 1:
  - stallF_o, stallD_o, flushD_o and flushE_o are forced to 0, because the pipeline is frozen.
  - Pending branch flushes and load-use stalls re-evaluate after the freeze, since their stage inputs are held stable.
- Timeout:
  - An internal counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching MISS_TIMEOUT, error_o is set and stays set until reset. The FSM stays in WAIT.
- Reset (rst_ni = 0 at a clock edge):
  - State goes to RUN; refill_req_o, error_o and the timeout counter go to 0.
  - While rst_ni = 0, all outputs are driven 0, including the combinational ones.
  - A reset arriving in REQ or WAIT abandons the refill with no further request.
- Latency:
  - Forwarding, stall and flush outputs: 0 cycles.
  - refill_req_o: 1 cycle after the miss.
  - Minimum miss penalty: 4 frozen cycles, with refill_done_i arriving in the first WAIT cycle.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, add outputs stall_cycles_o [CNT_WIDTH] and flush_count_o [CNT_WIDTH], both reset to 0:
  - stall_cycles_o increments on each cycle with mem_stall_o or lw_stall.
  - flush_count_o increments on each cycle with flushD_o = 1.
  - Both counters wrap at 2^CNT_WIDTH.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg:
  - enum fwd_sel_t: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - enum haz_state_t: RUN, REQ, WAIT, RESUME.
  - constant RESULT_SRC_LOAD = 2'b01.
- Sub-module hazard_fwd: combinational forwarding comparator, instantiated once per operand (A and B).

Test Plan:
- Forwarding: rs1E = 5, rdM = 5, reg_writeM = 1, rdW = 5, reg_writeW = 1 → forwardAE = 2'b10. Then set rdM = 0 → forwardAE = 2'b01. Then rs1E = 0 → 2'b00.
- Load-use: result_srcE = 01, rdE = 7, rs2D = 7 → stallF = stallD = flushE = 1 and flushD = 0 for 1 cycle. Same stimulus with rdE = 0 → all 0.
- Branch: pc_srcE = 1 with no miss → flushD = flushE = 1 and stallF = 0.
- Miss sequence: cache_missM = 1 at cycle t → mem_stall = 1 from t; refill_req = 1 only at t+1; refill_done at t+3 → RESUME at t+4; mem_stall = 0 at t+5. Also assert pc_srcE = 1 throughout → flushD = 0 during the freeze and 1 at t+5.
- Timeout: MISS_TIMEOUT = 4, refill_done never asserted → error_o = 1 after 4 WAIT cycles and held. Then rst_ni = 0 → error_o = 0, state = RUN, mem_stall = 0.
- Reset in WAIT: drop rst_ni while in WAIT → no further refill_req pulse; the first miss after reset restarts at REQ. With HAZARD_PERF_EN defined, the counters read 0 after this reset.
